// File: rtl/native_mem_arbiter_pkg.sv
// Shared types and constants for the native memory arbiter family.
// Holds the arbiter state encoding, native bus widths, the read data
// returned on a forced completion, and a helper for index widths.
package native_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Width of a requester index; never narrower than one bit.
  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/native_mem_arbiter_if.sv
// Bundle of requester-side and downstream native memory signals.
// The master modport is the arbiter's view; slave is the view of the
// surrounding system (requesters plus the downstream adapter).
interface native_mem_arbiter_if
  import native_mem_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  localparam int IDX_W = idxWidth(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_instr;
  logic [ADDR_W*NUM_REQ-1:0] req_addr;
  logic [DATA_W*NUM_REQ-1:0] req_wdata;
  logic [STRB_W*NUM_REQ-1:0] req_wstrb;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         req_rdata;

  logic                      mem_valid;
  logic                      mem_instr;
  logic [ADDR_W-1:0]         mem_addr;
  logic [DATA_W-1:0]         mem_wdata;
  logic [STRB_W-1:0]         mem_wstrb;
  logic                      mem_ready;
  logic [DATA_W-1:0]         mem_rdata;

  logic [IDX_W-1:0]          grant_idx;
  logic                      busy;
  logic                      timeout_err;

  modport master (
    input  req_valid, req_instr, req_addr, req_wdata, req_wstrb,
    output req_ready, req_rdata,
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    output grant_idx, busy, timeout_err
  );

  modport slave (
    output req_valid, req_instr, req_addr, req_wdata, req_wstrb,
    input  req_ready, req_rdata,
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    input  grant_idx, busy, timeout_err
  );

endinterface

// File: rtl/native_mem_arbiter_rr_priority_pick.sv
// Round-robin priority picker: finds the first set request bit at or
// above i_ptr, wrapping modulo NUM_REQ. Purely combinational so it can
// be dropped into other arbiters unchanged.
module rr_priority_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx
);

  // Walk the requesters starting at the pointer; first hit wins.
  always_comb begin
    logic found;
    int   pos;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(i_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (!found && i_req[pos]) begin
        found        = 1'b1;
        o_grant[pos] = 1'b1;
        o_idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/native_mem_arbiter.sv
// Round-robin arbiter sharing one native (PicoRV32-style) memory port
// between NUM_REQ requesters, one transaction at a time, with at least
// one idle cycle between transactions.
// Optional build macro NATIVE_MEM_ARB_TIMEOUT_EN adds a BUSY watchdog
// that forces completion with TIMEOUT_RDATA and sets a sticky flag.
module native_mem_arbiter
  import native_mem_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  native_mem_arbiter_if.master bus
);

  localparam int IDX_W = idxWidth(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_paramCheck
    $error("native_mem_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
  end

  state_e             r_state;
  logic [IDX_W-1:0]   r_grantIdx;
  logic [IDX_W-1:0]   r_rrPtr;
  logic               r_busy;

  logic [NUM_REQ-1:0] w_pickOneHot;
  logic [IDX_W-1:0]   w_pickIdx;
  logic               w_anyReq;
  logic               w_inBusy;
  logic               w_grantValid;
  logic               w_timeoutHit;
  logic               w_memValid;
  logic               w_done;
  logic               w_ack;
  logic               w_leaveBusy;
  logic [IDX_W-1:0]   w_nextPtr;
  logic [NUM_REQ-1:0] w_reqReady;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_ptr   (r_rrPtr),
    .o_grant (w_pickOneHot),
    .o_idx   (w_pickIdx)
  );

  assign w_anyReq     = |w_pickOneHot;
  assign w_inBusy     = (r_state == BUSY);
  assign w_grantValid = bus.req_valid[r_grantIdx];

`ifdef NATIVE_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_toCount;
  logic             r_timeoutErr;

  assign w_timeoutHit = w_inBusy && w_grantValid && !bus.mem_ready &&
                        (r_toCount == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus.req_rdata = w_timeoutHit ? TIMEOUT_RDATA : bus.mem_rdata;
  assign bus.timeout_err = r_timeoutErr;
`else
  assign w_timeoutHit    = 1'b0;
  assign bus.req_rdata   = bus.mem_rdata;
  assign bus.timeout_err = 1'b0;
`endif

  // A dropped req_valid, a real completion or a forced one all end BUSY;
  // only the last two acknowledge the requester.
  assign w_memValid  = w_inBusy && w_grantValid && !w_timeoutHit;
  assign w_done      = w_memValid && bus.mem_ready;
  assign w_ack       = w_done || w_timeoutHit;
  assign w_leaveBusy = w_inBusy && (!w_grantValid || w_ack);
  assign w_nextPtr   = (r_grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : r_grantIdx + 1'b1;

  // Steer the acknowledge to the granted requester only.
  always_comb begin
    w_reqReady = '0;
    if (w_ack) begin
      w_reqReady[r_grantIdx] = 1'b1;
    end
  end

  assign bus.req_ready = w_reqReady;
  assign bus.mem_valid = w_memValid;
  assign bus.mem_instr = bus.req_instr[r_grantIdx];
  assign bus.mem_addr  = bus.req_addr[ADDR_W*r_grantIdx +: ADDR_W];
  assign bus.mem_wdata = bus.req_wdata[DATA_W*r_grantIdx +: DATA_W];
  assign bus.mem_wstrb = bus.req_wstrb[STRB_W*r_grantIdx +: STRB_W];
  assign bus.grant_idx = r_grantIdx;
  assign bus.busy      = r_busy;

  // Arbitration FSM: grant from IDLE, release from BUSY and advance the pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grantIdx   <= '0;
      r_rrPtr      <= '0;
      r_busy       <= 1'b0;
`ifdef NATIVE_MEM_ARB_TIMEOUT_EN
      r_toCount    <= '0;
      r_timeoutErr <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state    <= BUSY;
            r_grantIdx <= w_pickIdx;
            r_busy     <= 1'b1;
`ifdef NATIVE_MEM_ARB_TIMEOUT_EN
            r_toCount  <= '0;
`endif
          end
        end
        BUSY: begin
          if (w_leaveBusy) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_rrPtr <= w_nextPtr;
          end
`ifdef NATIVE_MEM_ARB_TIMEOUT_EN
          if (w_timeoutHit) begin
            r_timeoutErr <= 1'b1;
          end
          if (!bus.mem_ready) begin
            r_toCount <= r_toCount + 1'b1;
          end
`endif
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_native_mem_arbiter.sv
// Self-checking bench for native_mem_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=8).
// A transaction-level model tracks which requester owns the port and
// checks every DUT output each cycle; directed tests add literal checks.
// Build with NATIVE_MEM_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_native_mem_arbiter;
  import native_mem_pkg::*;

  localparam int NUM_REQ        = 2;
  localparam int TIMEOUT_CYCLES = 8;
`ifdef NATIVE_MEM_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;

  native_mem_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  native_mem_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model state: owner of the port (-1 = nobody), round-robin start point,
  // last granted index, BUSY cycles spent waiting, sticky timeout flag.
  int mOwner = -1;
  int mPtr   = 0;
  int mGrant = 0;
  int mWait  = 0;
  bit mErr   = 1'b0;

  int grantLog[$];
  bit prevDone = 1'b0;
  int gapViolations = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int idx, input bit valid, input bit instr,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb);
    bus.req_valid[idx]          = valid;
    bus.req_instr[idx]          = instr;
    bus.req_addr[32*idx +: 32]  = addr;
    bus.req_wdata[32*idx +: 32] = wdata;
    bus.req_wstrb[4*idx +: 4]   = wstrb;
  endtask

  task automatic driveMem(input bit ready, input logic [31:0] rdata);
    bus.mem_ready = ready;
    bus.mem_rdata = rdata;
  endtask

  task automatic clearInputs();
    bus.req_valid = '0;
    bus.req_instr = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wstrb = '0;
    driveMem(1'b0, 32'h0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    nextCycle();
    reset = 1'b1;
    clearInputs();
    nextCycle();
    reset = 1'b0;
  endtask

  function automatic int pickFrom(input int ptr, input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic timeoutNow();
    if (!TO_EN || mOwner < 0) return 1'b0;
    return bus.req_valid[mOwner] && !bus.mem_ready && (mWait + 1 == TIMEOUT_CYCLES);
  endfunction

  // Model update at each clock edge from the inputs held over the cycle.
  always @(posedge clk or posedge reset) begin : modelProc
    if (reset) begin
      mOwner <= -1;
      mPtr   <= 0;
      mGrant <= 0;
      mWait  <= 0;
      mErr   <= 1'b0;
    end else if (mOwner < 0) begin
      if (bus.req_valid != '0) begin
        mOwner <= pickFrom(mPtr, bus.req_valid);
        mGrant <= pickFrom(mPtr, bus.req_valid);
        mWait  <= 0;
      end
    end else if (!bus.req_valid[mOwner] || bus.mem_ready || timeoutNow()) begin
      mOwner <= -1;
      mPtr   <= (mOwner + 1) % NUM_REQ;
      if (timeoutNow()) mErr <= 1'b1;
    end else begin
      mWait <= mWait + 1;
    end
  end

  // Compare every DUT output against the model in the middle of each cycle.
  always @(negedge clk) begin : compareProc
    logic                toNow;
    logic                expValid;
    logic [NUM_REQ-1:0]  expReady;
    if (!reset) begin
      toNow    = timeoutNow();
      expValid = (mOwner >= 0) && bus.req_valid[mOwner] && !toNow;
      expReady = '0;
      if ((expValid && bus.mem_ready) || toNow) expReady[mOwner] = 1'b1;
      checkOutput("cmp mem_valid", bus.mem_valid, expValid);
      checkOutput("cmp req_ready", bus.req_ready, expReady);
      checkOutput("cmp grant_idx", bus.grant_idx, mGrant);
      checkOutput("cmp busy", bus.busy, mOwner >= 0);
      checkOutput("cmp timeout_err", bus.timeout_err, mErr);
      if (expValid) begin
        checkOutput("cmp mem_addr", bus.mem_addr, bus.req_addr[32*mOwner +: 32]);
        checkOutput("cmp mem_wdata", bus.mem_wdata, bus.req_wdata[32*mOwner +: 32]);
        checkOutput("cmp mem_wstrb", bus.mem_wstrb, bus.req_wstrb[4*mOwner +: 4]);
        checkOutput("cmp mem_instr", bus.mem_instr, bus.req_instr[mOwner]);
      end
      if (expReady != '0) begin
        checkOutput("cmp req_rdata", bus.req_rdata, toNow ? 32'hDEAD_BEEF : bus.mem_rdata);
      end
    end
  end

  // Log completed grants and catch a new transaction starting right after one ends.
  always @(negedge clk) begin : logProc
    if (reset) begin
      prevDone <= 1'b0;
    end else begin
      if (bus.mem_valid && prevDone) gapViolations <= gapViolations + 1;
      if (bus.mem_valid && bus.mem_ready) grantLog.push_back(int'(bus.grant_idx));
      prevDone <= bus.mem_valid && bus.mem_ready;
    end
  end

  initial begin : watchdog
    #200000;
    nErrors++;
    $display("[TB] FAIL watchdog: got timeout, expected test end");
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin : mainSeq
    int expOrder[4];
    expOrder = '{0, 1, 0, 1};
    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_valid", bus.mem_valid, 0);
    checkOutput("reset req_ready", bus.req_ready, 0);
    checkOutput("reset grant_idx", bus.grant_idx, 0);
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset timeout_err", bus.timeout_err, 0);

    // Single read from requester 0
    nextCycle();
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    @(negedge clk); checkOutput("t1 idle first", bus.mem_valid, 0);
    nextCycle();
    @(negedge clk); checkOutput("t1 mem_valid", bus.mem_valid, 1);
    checkOutput("t1 mem_addr", bus.mem_addr, 32'h0000_1000);
    nextCycle();
    nextCycle(); driveMem(1'b1, 32'h1234_5678);
    @(negedge clk); checkOutput("t1 req_ready", bus.req_ready, 2'b01);
    checkOutput("t1 req_rdata", bus.req_rdata, 32'h1234_5678);
    nextCycle(); applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); driveMem(1'b0, 32'h0);
    @(negedge clk); checkOutput("t1 gap mem_valid", bus.mem_valid, 0);
    checkOutput("t1 gap req_ready", bus.req_ready, 0);

    // Contention from reset: grants must alternate
    doReset();
    grantLog.delete();
    applyStimulus(0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
    driveMem(1'b1, 32'hA5A5_0000);
    repeat (8) nextCycle();
    clearInputs();
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("t2 rr grant %0d", k),
                  (k < grantLog.size()) ? 32'(grantLog[k]) : 32'hFFFF_FFFF, expOrder[k]);
    end

    // Write passthrough from requester 1
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h4000_0010, 32'hCAFE_F00D, 4'b0011);
    nextCycle();
    @(negedge clk); checkOutput("t3 mem_valid", bus.mem_valid, 1);
    checkOutput("t3 mem_addr", bus.mem_addr, 32'h4000_0010);
    checkOutput("t3 mem_wdata", bus.mem_wdata, 32'hCAFE_F00D);
    checkOutput("t3 mem_wstrb", bus.mem_wstrb, 4'b0011);
    checkOutput("t3 mem_instr", bus.mem_instr, 0);
    checkOutput("t3 req_ready0 a", bus.req_ready[0], 0);
    nextCycle();
    @(negedge clk); checkOutput("t3 req_ready0 b", bus.req_ready[0], 0);
    nextCycle(); driveMem(1'b1, 32'hFFFF_0000);
    @(negedge clk); checkOutput("t3 req_ready", bus.req_ready, 2'b10);
    nextCycle(); clearInputs();

    // Back-to-back reads from requester 0
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
    driveMem(1'b1, 32'h1111_2222);
    nextCycle();
    @(negedge clk); checkOutput("t4 first ready", bus.req_ready, 2'b01);
    checkOutput("t4 first addr", bus.mem_addr, 32'h0000_2000);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_2004, 32'h0, 4'h0);
    driveMem(1'b1, 32'h3333_4444);
    @(negedge clk); checkOutput("t4 idle gap", bus.mem_valid, 0);
    nextCycle();
    @(negedge clk); checkOutput("t4 second valid", bus.mem_valid, 1);
    checkOutput("t4 second addr", bus.mem_addr, 32'h0000_2004);
    checkOutput("t4 second rdata", bus.req_rdata, 32'h3333_4444);
    nextCycle(); clearInputs();

    // Reset while requester 1 holds the port
    nextCycle();
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'h0);
    nextCycle();
    @(negedge clk); checkOutput("t5 granted 1", bus.grant_idx, 1);
    checkOutput("t5 mem_valid", bus.mem_valid, 1);
    #2 reset = 1'b1;
    #1 checkOutput("t5 async mem_valid", bus.mem_valid, 0);
    checkOutput("t5 async grant_idx", bus.grant_idx, 0);
    checkOutput("t5 async busy", bus.busy, 0);
    nextCycle(); reset = 1'b0;
    @(negedge clk); checkOutput("t5 after grant_idx", bus.grant_idx, 0);
    checkOutput("t5 after mem_valid", bus.mem_valid, 0);
    nextCycle();
    @(negedge clk); checkOutput("t5 regrant 1", bus.grant_idx, 1);
    checkOutput("t5 regrant addr", bus.mem_addr, 32'h0000_5000);
    nextCycle(); driveMem(1'b1, 32'h5555_AAAA);
    @(negedge clk); checkOutput("t5 ready", bus.req_ready, 2'b10);
    nextCycle(); clearInputs();

    // Requester 0 drops valid mid-transaction; pointer must still advance
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'h0);
    nextCycle();
    @(negedge clk); checkOutput("t7 granted 0", bus.mem_valid, 1);
    nextCycle();
    applyStimulus(0, 1'b0, 1'b0, 32'h0000_7000, 32'h0, 4'h0);
    applyStimulus(1, 1'b1, 1'b0, 32'h0000_7100, 32'h0, 4'h0);
    driveMem(1'b1, 32'h7777_0000);
    @(negedge clk); checkOutput("t7 drop valid", bus.mem_valid, 0);
    checkOutput("t7 drop ready", bus.req_ready, 0);
    nextCycle();
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_7004, 32'h0, 4'h0);
    nextCycle();
    @(negedge clk); checkOutput("t7 rr after drop", bus.grant_idx, 1);
    checkOutput("t7 ready 1", bus.req_ready, 2'b10);
    nextCycle(); clearInputs();
    nextCycle();

    // Downstream never answers
    applyStimulus(0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
    driveMem(1'b0, 32'h1212_1212);
    for (int b = 1; b < TIMEOUT_CYCLES; b++) begin
      nextCycle();
      @(negedge clk); checkOutput($sformatf("t6 wait %0d", b), {bus.mem_valid, bus.req_ready}, 3'b100);
    end
`ifdef NATIVE_MEM_ARB_TIMEOUT_EN
    nextCycle();
    @(negedge clk); checkOutput("t6 forced ready", bus.req_ready, 2'b01);
    checkOutput("t6 forced rdata", bus.req_rdata, 32'hDEAD_BEEF);
    checkOutput("t6 forced mem_valid", bus.mem_valid, 0);
    nextCycle(); clearInputs();
    @(negedge clk); checkOutput("t6 err set", bus.timeout_err, 1);
    repeat (3) nextCycle();
    @(negedge clk); checkOutput("t6 err sticky", bus.timeout_err, 1);
    doReset();
    @(negedge clk); checkOutput("t6 err cleared", bus.timeout_err, 0);
`else
    repeat (4) nextCycle();
    @(negedge clk); checkOutput("t6 still waiting", bus.mem_valid, 1);
    checkOutput("t6 no err", bus.timeout_err, 0);
    checkOutput("t6 no ready", bus.req_ready, 0);
    nextCycle(); driveMem(1'b1, 32'h6666_0000);
    @(negedge clk); checkOutput("t6 late ready", bus.req_ready, 2'b01);
    nextCycle(); clearInputs();
`endif
    nextCycle();
    checkOutput("gap violations", gapViolations, 0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/native_mem_arbiter.md
Name: native_mem_arbiter

Overview:
- Shares one native PicoRV32-style memory port between NUM_REQ requesters. Typical requesters are the CPU instruction/data port and the Ethernet descriptor/DMA engine.
- Sits directly upstream of the native-to-AXI4-lite adapter. Drives that adapter's native port with one transaction at a time.
- Arbitration is round-robin, with a guaranteed idle cycle between transactions so the adapter's per-transaction ack flags clear.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 1024, BUSY-cycle limit before forced completion (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester mem_valid.
- req_instr  in  NUM_REQ  per-requester mem_instr.
- req_addr  in  32*NUM_REQ  flattened addresses; requester i occupies [32*i+:32].
- req_wdata  in  32*NUM_REQ  flattened write data.
- req_wstrb  in  4*NUM_REQ  flattened byte strobes; all-zero means read.
- req_ready  out  NUM_REQ  per-requester mem_ready.
- req_rdata  out  32  shared read data; valid only for the requester whose req_ready is high.
- mem_valid  out  1  downstream native port.
- mem_instr  out  1  downstream native port.
- mem_addr  out  32  downstream native port.
- mem_wdata  out  32  downstream native port.
- mem_wstrb  out  4  downstream native port.
- mem_ready  in  1  downstream native port.
- mem_rdata  in  32  downstream native port.
- grant_idx  out  clog2(NUM_REQ), min 1  index of the current or last granted requester.
- busy  out  1  high while in BUSY.
- timeout_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE, grant_idx=0, rr_ptr=0, mem_valid=0, req_ready=0, busy=0, timeout_err=0.
- States: IDLE, BUSY.
- IDLE:
  - mem_valid=0, all req_ready=0.
  - If any req_valid is high, select the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Register it into grant_idx and go to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - mem_valid = req_valid[grant_idx]. mem_instr/addr/wdata/wstrb are muxed combinationally from grant_idx.
  - req_ready[grant_idx] = mem_ready. All other req_ready bits are 0. req_rdata = mem_rdata (pass-through, 0 added latency).
- BUSY to IDLE happens on mem_valid && mem_ready, which sets rr_ptr = grant_idx+1 (wrapping at NUM_REQ).
- Latency: a request first seen at cycle t gives mem_valid at t+1. Completion is in the same cycle as downstream mem_ready.
- Minimum spacing: IDLE always lasts at least 1 cycle, so mem_valid is low for at least one cycle between any two transactions, including back-to-back requests from the same requester.
- Requester drops req_valid while BUSY (a protocol violation): mem_valid falls in the same cycle, state returns to IDLE, and rr_ptr advances. No req_ready is issued.
- mem_ready while not BUSY: ignored.
- Simultaneous requests: round-robin order. A requester that has just been served has lowest priority on the next arbitration.
- A new req_valid that rises while BUSY is only considered at the next IDLE.
- Reset asserted mid-transaction: immediate return to reset values. mem_valid drops asynchronously and the downstream transaction is abandoned.

Optional Feature:
- Macro: NATIVE_MEM_ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the count equals TIMEOUT_CYCLES-1 and mem_ready is still low, the arbiter forces completion. In that cycle: req_ready[grant_idx]=1, req_rdata=32'hDEAD_BEEF, mem_valid=0.
  - It then sets timeout_err (sticky until reset) and goes to IDLE with rr_ptr advanced.
- Without the macro: no counter is built, BUSY waits indefinitely, and timeout_err is tied to 0.

Decomposition:
- Shared package native_mem_pkg holds:
  - the state enum (IDLE, BUSY);
  - localparams for native widths: ADDR_W=32, DATA_W=32, STRB_W=4;
  - the constant TIMEOUT_RDATA=32'hDEAD_BEEF.
- One sub-module is natural: rr_priority_pick. Inputs are request vector and rr_ptr; outputs are a one-hot grant plus its index. It is purely combinational and reused by later arbiters.

Test Plan:
1. Single read: req0 valid at 0x0000_1000, wstrb=0. Expected: mem_valid rises 1 cycle later with mem_addr=0x1000. Downstream returns mem_ready with rdata=0x1234_5678 two cycles later. Expected: req_ready[0] is high for exactly that cycle with req_rdata=0x1234_5678, then mem_valid=0 for at least 1 cycle.
2. Contention: req0 and req1 request continuously from reset. Expected: grants alternate 0,1,0,1 and each grant is separated by one IDLE cycle with mem_valid=0.
3. Write passthrough: req1 writes addr=0x4000_0010, wdata=0xCAFE_F00D, wstrb=4'b0011. Expected: downstream sees identical fields and mem_instr=0. req_ready[0] stays 0 throughout.
4. Back-to-back from the same requester: req0 issues two reads with req1 idle. Expected: the second mem_valid appears 1 idle cycle after the first completion.
5. Reset mid-transaction: assert reset while BUSY with req1 granted. Expected: mem_valid=0 within the same cycle (async). After release, grant_idx=0 and a pending req1 is granted next.
6. With NUM_REQ=2, TIMEOUT_CYCLES=8, and NATIVE_MEM_ARB_TIMEOUT_EN defined: downstream never asserts mem_ready. Expected: on the 8th BUSY cycle, req_ready pulses with req_rdata=0xDEAD_BEEF and timeout_err=1, which stays set until reset.
